// File: rtl/input_debounce_sync_pkg.sv
// Shared definitions for the input debounce/synchroniser stage:
// channel FSM encoding and default sizing constants.
package input_debounce_sync_pkg;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } chan_state_e;

    localparam int unsigned DEF_CNT_W         = 8;
    localparam int unsigned DEF_STABLE_CYCLES = 200;

endpackage

// File: rtl/input_debounce_sync_chan.sv
// Single-bit channel: 2-flop synchroniser, stability-counter debouncer,
// and registered one-cycle rise/fall pulses.
module debounce_chan
    import input_debounce_sync_pkg::*;
#(
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1, s2;
    chan_state_e      state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             level_nx, rise_nx, fall_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        if (ena) begin
            case (state)
                ST_STABLE: begin
                    if (s2 != level) begin
                        // A one-cycle window accepts the new level immediately
                        if (STABLE_CYCLES == 1) begin
                            level_nx = ~level;
                            rise_nx  = ~level;
                            fall_nx  = level;
                        end else begin
                            state_nx = ST_PENDING;
                            cnt_nx   = CNT_W'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (s2 == level) begin
                        state_nx = ST_STABLE;
                        cnt_nx   = '0;
                    end else if (cnt == LAST) begin
                        state_nx = ST_STABLE;
                        cnt_nx   = '0;
                        level_nx = ~level;
                        rise_nx  = ~level;
                        fall_nx  = level;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = ST_STABLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ST_STABLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= level_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/input_debounce_sync.sv
// Multi-channel pad conditioning: one independent debounce channel per
// input bit, with a combined busy flag.
module input_debounce_sync
    import input_debounce_sync_pkg::*;
#(
    parameter int unsigned CHANNELS      = 3,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic                busy
);

    logic [CHANNELS-1:0] chan_busy;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_chan #(
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .ena  (ena),
            .btn  (btn_in[g]),
            .level(btn_level[g]),
            .rise (btn_rise[g]),
            .fall (btn_fall[g]),
            .busy (chan_busy[g])
        );
    end

    // Each channel's busy comes straight from its counter register
    assign busy = |chan_busy;

endmodule

// File: tb/tb_input_debounce_sync.sv
// Bench for input_debounce_sync: table vectors, directed corner sequences
// and randomized stimulus against a run-length reference model.
module tb_input_debounce_sync;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [2:0] btn_in, btn_level, btn_rise, btn_fall;
    logic       busy;

    int total = 0;
    int bad   = 0;

    input_debounce_sync #(
        .CHANNELS     (3),
        .CNT_W        (4),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: pin pipeline plus run length of differing samples
    int         m_s1[3], m_s2[3], m_lvl[3], m_run[3];
    logic [2:0] m_rise, m_fall;

    typedef struct {
        logic       r;
        logic       e;
        logic [2:0] b;
        logic [2:0] lvl;
        logic [2:0] ris;
        logic [2:0] fal;
        logic       bsy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic [2:0] b);
        for (int c = 0; c < 3; c++) begin
            if (!r) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
                m_rise[c] = 1'b0; m_fall[c] = 1'b0;
            end else begin
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (e) begin
                    if (m_s2[c] != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == SC) begin
                            m_lvl[c] = 1 - m_lvl[c];
                            m_run[c] = 0;
                            if (m_lvl[c] == 1) m_rise[c] = 1'b1;
                            else m_fall[c] = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = int'(b[c]);
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] b);
        logic [2:0] lv;
        logic       bz;
        rst_n  = r;
        ena    = e;
        btn_in = b;
        @(posedge clk);
        #1;
        model_step(r, e, b);
        bz = 1'b0;
        for (int c = 0; c < 3; c++) begin
            lv[c] = (m_lvl[c] != 0);
            if (m_run[c] != 0) bz = 1'b1;
        end
        chk("model_level", btn_level, lv);
        chk("model_rise", btn_rise, m_rise);
        chk("model_fall", btn_fall, m_fall);
        chk("model_busy", {2'b00, busy}, {2'b00, bz});
    endtask

    task automatic add(input logic r, input logic e, input logic [2:0] b,
                       input logic [2:0] lvl, input logic [2:0] ris,
                       input logic [2:0] fal, input logic bsy);
        vec_t v;
        v.r = r; v.e = e; v.b = b; v.lvl = lvl; v.ris = ris; v.fal = fal; v.bsy = bsy;
        tbl.push_back(v);
    endtask

    initial begin
        logic [2:0] rb;
        logic       re, rr;

        rst_n = 1'b0; ena = 1'b1; btn_in = 3'b000;
        for (int c = 0; c < 3; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
        end
        m_rise = '0; m_fall = '0;

        // Reset with pins high, then release and accept 111
        for (int i = 0; i < 3; i++) add(0, 1, 3'b111, 3'b000, 3'b000, 3'b000, 0);
        add(1, 1, 3'b111, 3'b000, 3'b000, 3'b000, 0);
        add(1, 1, 3'b111, 3'b000, 3'b000, 3'b000, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 3'b111, 3'b000, 3'b000, 3'b000, 1);
        add(1, 1, 3'b111, 3'b111, 3'b111, 3'b000, 0);
        add(1, 1, 3'b111, 3'b111, 3'b000, 3'b000, 0);
        // Clean step on ch0
        add(0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        add(1, 1, 3'b001, 3'b000, 3'b000, 3'b000, 0);
        add(1, 1, 3'b001, 3'b000, 3'b000, 3'b000, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 3'b001, 3'b000, 3'b000, 3'b000, 1);
        add(1, 1, 3'b001, 3'b001, 3'b001, 3'b000, 0);
        add(1, 1, 3'b001, 3'b001, 3'b000, 3'b000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].b);
            chk("tbl_level", btn_level, tbl[i].lvl);
            chk("tbl_rise", btn_rise, tbl[i].ris);
            chk("tbl_fall", btn_fall, tbl[i].fal);
            chk("tbl_busy", {2'b00, busy}, {2'b00, tbl[i].bsy});
        end

        // Bounce on ch1: two-cycle toggles never complete a window
        for (int i = 0; i < 8; i++) begin
            step(1, 1, {1'b0, ((i / 2) % 2 == 0), 1'b1});
            chk("bounce_level", btn_level, 3'b001);
            chk("bounce_rise", btn_rise, 3'b000);
        end
        for (int k = 0; k < 6; k++) begin
            step(1, 1, 3'b011);
            chk("hold_level", btn_level, (k == 5) ? 3'b011 : 3'b001);
            chk("hold_rise", btn_rise, (k == 5) ? 3'b010 : 3'b000);
        end

        // Simultaneous fall on ch0 and ch2
        step(0, 1, 3'b101);
        for (int k = 0; k < 7; k++) step(1, 1, 3'b101);
        chk("pre_fall_level", btn_level, 3'b101);
        for (int k = 0; k < 6; k++) begin
            step(1, 1, 3'b000);
            chk("simul_fall", btn_fall, (k == 5) ? 3'b101 : 3'b000);
        end
        chk("simul_level", btn_level, 3'b000);

        // ena freeze after two pending edges
        for (int k = 0; k < 4; k++) step(1, 1, 3'b010);
        chk("freeze_busy_pre", {2'b00, busy}, 3'b001);
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 3'b010);
            chk("freeze_rise", btn_rise, 3'b000);
            chk("freeze_level", btn_level, 3'b000);
            chk("freeze_busy", {2'b00, busy}, 3'b001);
        end
        step(1, 1, 3'b010);
        chk("resume1_level", btn_level, 3'b000);
        step(1, 1, 3'b010);
        chk("resume2_level", btn_level, 3'b010);
        chk("resume2_rise", btn_rise, 3'b010);

        // Reset while ch2 is one edge from accepting
        for (int k = 0; k < 5; k++) step(1, 1, 3'b110);
        chk("midrst_busy_pre", {2'b00, busy}, 3'b001);
        chk("midrst_level_pre", btn_level, 3'b010);
        step(0, 1, 3'b110);
        chk("midrst_level", btn_level, 3'b000);
        chk("midrst_rise", btn_rise, 3'b000);
        chk("midrst_fall", btn_fall, 3'b000);
        chk("midrst_busy", {2'b00, busy}, 3'b000);
        step(0, 1, 3'b110);
        chk("midrst_rise2", btn_rise, 3'b000);

        // Randomized slow-changing pins, occasional ena drop and reset
        rb = 3'b000;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 5) == 0) rb[c] = ~rb[c];
            re = ($urandom_range(0, 7) != 0);
            rr = ($urandom_range(0, 199) != 0);
            step(rr, re, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
